// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StHunt,
      StCount,
      StData,
      StCheck,
      StDone,
      StError
   } ldr_state_t;

   localparam logic [7:0] LDR_SYNC_DEFAULT = 8'hA5;

   // A word count is legal when non-zero and no larger than the imem capacity.
   function automatic logic count_legal(input logic [7:0] n, input int unsigned addr_w);
      if (n == 8'd0) begin
         return 1'b0;
      end
      if (addr_w >= 8) begin
         return 1'b1;
      end
      return 32'(n) <= (32'd1 << addr_w);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle of the program loader.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 6
) ();

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;

   // Loader side.
   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output im_we,
      output im_addr,
      output im_wdata
   );

   // Byte source / imem side.
   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  im_we,
      input  im_addr,
      input  im_wdata
   );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Big-endian 8-to-32 packer: word_valid marks the byte that completes a word,
// and word presents the assembled value in that same cycle.
module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear) begin
         shift_d = 24'd0;
         cnt_d   = 2'd0;
      end else if (byte_valid) begin
         shift_d = {shift_q[15:0], byte_data};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   assign word       = {shift_q, byte_data};
   assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= 24'd0;
         cnt_q   <= 2'd0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes words into imem and holds the core
// in reset until the whole frame has been written and its checksum verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter logic [7:0]  SYNC   = LDR_SYNC_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   imem_loader_if.master    bus,
   output logic             cpu_reset,
   output logic             done,
   output logic             err
);

   ldr_state_t        state_q, state_d;
   logic [7:0]        widx_q, widx_d;
   logic [7:0]        last_q, last_d;
   logic [7:0]        csum_q, csum_d;
   logic              rx_ready_q;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [31:0]       im_wdata_q, im_wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic        fire;
   logic        idle_state;
   logic        sync_seen;
   logic        pack_valid;
   logic [31:0] pack_word;
   logic        pack_word_valid;

   assign fire       = bus.rx_valid && rx_ready_q;
   assign idle_state = (state_q == StHunt) || (state_q == StDone) || (state_q == StError);
   assign sync_seen  = fire && idle_state && (bus.rx_data == SYNC);
   assign pack_valid = fire && (state_q == StData);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (sync_seen),
      .byte_valid (pack_valid),
      .byte_data  (bus.rx_data),
      .word       (pack_word),
      .word_valid (pack_word_valid)
   );

   always_comb begin
      state_d     = state_q;
      widx_d      = widx_q;
      last_d      = last_q;
      csum_d      = csum_q;
      im_we_d     = 1'b0;
      im_addr_d   = im_addr_q;
      im_wdata_d  = im_wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      err_d       = err_q;

      unique case (state_q)
         StHunt, StDone, StError: begin
            if (sync_seen) begin
               state_d     = StCount;
               done_d      = 1'b0;
               err_d       = 1'b0;
               cpu_reset_d = 1'b1;
               widx_d      = 8'd0;
               csum_d      = 8'd0;
            end
         end
         StCount: begin
            if (fire) begin
               if (count_legal(bus.rx_data, ADDR_W)) begin
                  last_d  = bus.rx_data - 8'd1;
                  state_d = StData;
               end else begin
                  state_d = StError;
                  err_d   = 1'b1;
               end
            end
         end
         StData: begin
            if (fire) begin
               csum_d = csum_q ^ bus.rx_data;
               if (pack_word_valid) begin
                  im_we_d    = 1'b1;
                  im_addr_d  = ADDR_W'(widx_q);
                  im_wdata_d = pack_word;
                  widx_d     = widx_q + 8'd1;
                  if (widx_q == last_q) begin
                     state_d = StCheck;
                  end
               end
            end
         end
         StCheck: begin
            if (fire) begin
               if (bus.rx_data == csum_q) begin
                  state_d     = StDone;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  // Words already written stay in imem; the core remains in reset.
                  state_d = StError;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StHunt;
         widx_q      <= 8'd0;
         last_q      <= 8'd0;
         csum_q      <= 8'd0;
         rx_ready_q  <= 1'b0;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= 32'd0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         widx_q      <= widx_d;
         last_q      <= last_d;
         csum_q      <= csum_d;
         rx_ready_q  <= 1'b1;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.im_we    = im_we_q;
   assign bus.im_addr  = im_addr_q;
   assign bus.im_wdata = im_wdata_q;
   assign cpu_reset    = cpu_reset_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with ADDR_W=6: frames, checksum/count errors and resets.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cpu_reset;
   logic done;
   logic err;

   imem_loader_if #(.ADDR_W(6)) bus ();

   imem_loader #(
      .ADDR_W (6),
      .SYNC   (8'hA5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Write log captured from the imem port; tasks snapshot wr_total as a base.
   int          wr_total = 0;
   logic [5:0]  log_addr [1024];
   logic [31:0] log_data [1024];

   always @(posedge clk) begin
      if (bus.im_we === 1'b1 && wr_total < 1024) begin
         log_addr[wr_total] <= bus.im_addr;
         log_data[wr_total] <= bus.im_wdata;
         wr_total           <= wr_total + 1;
      end
   end

   logic [7:0] good_fr [11] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                8'hAC, 8'h02, 8'h00, 8'h54, 8'hD7};

   // Called at a negedge; returns at the negedge after the handshake plus idle cycles.
   task automatic send_byte(input logic [7:0] b, input int idle);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   task automatic send_frame(input int idle, input logic [7:0] csum);
      for (int i = 0; i < 10; i++) send_byte(good_fr[i], idle);
      send_byte(csum, idle);
   endtask

   function automatic logic [31:0] full_word(input int i);
      return {8'(i), 8'hC3 ^ 8'(i), 8'(i * 7), 8'h11};
   endfunction

   task automatic test_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      reset        = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rx_ready !== 1'b0) begin n_errors++; $display("FAIL rst_rx_ready: got %b want 0", bus.rx_ready); end
      n_checks++; if (bus.im_we !== 1'b0) begin n_errors++; $display("FAIL rst_im_we: got %b want 0", bus.im_we); end
      n_checks++; if (bus.im_addr !== 6'd0) begin n_errors++; $display("FAIL rst_im_addr: got %h want 0", bus.im_addr); end
      n_checks++; if (bus.im_wdata !== 32'd0) begin n_errors++; $display("FAIL rst_im_wdata: got %h want 0", bus.im_wdata); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_errors++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", done); end
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.rx_ready !== 1'b1) begin n_errors++; $display("FAIL rel_rx_ready: got %b want 1", bus.rx_ready); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_errors++; $display("FAIL rel_cpu_reset: got %b want 1", cpu_reset); end
   endtask

   task automatic test_good_frame(input int idle);
      int base;
      base = wr_total;
      for (int i = 0; i < 11; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = good_fr[i];
         @(negedge clk);
         bus.rx_valid = 1'b0;
         if (i == 4) begin
            n_checks++; if (bus.im_we !== 1'b0) begin n_errors++; $display("FAIL good_early_we idle=%0d: got %b want 0", idle, bus.im_we); end
         end
         if (i == 5) begin
            n_checks++; if (bus.im_we !== 1'b1) begin n_errors++; $display("FAIL good_we_latency idle=%0d: got %b want 1", idle, bus.im_we); end
            n_checks++; if (bus.im_wdata !== 32'h20080005) begin n_errors++; $display("FAIL good_wdata_latency idle=%0d: got %h want 20080005", idle, bus.im_wdata); end
         end
         if (i == 10) begin
            n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL good_done_latency idle=%0d: got %b want 1", idle, done); end
         end
         repeat (idle) @(negedge clk);
         if (i == 5 && idle > 0) begin
            n_checks++; if (bus.im_we !== 1'b0) begin n_errors++; $display("FAIL good_we_pulse idle=%0d: got %b want 0", idle, bus.im_we); end
            n_checks++; if (bus.im_wdata !== 32'h20080005) begin n_errors++; $display("FAIL good_wdata_hold idle=%0d: got %h want 20080005", idle, bus.im_wdata); end
         end
      end
      n_checks++; if (wr_total - base !== 2) begin n_errors++; $display("FAIL good_wr_count idle=%0d: got %0d want 2", idle, wr_total - base); end
      n_checks++; if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h20080005) begin n_errors++; $display("FAIL good_word0 idle=%0d: got %h/%h want 00/20080005", idle, log_addr[base], log_data[base]); end
      n_checks++; if (log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'hAC020054) begin n_errors++; $display("FAIL good_word1 idle=%0d: got %h/%h want 01/ac020054", idle, log_addr[base+1], log_data[base+1]); end
      n_checks++; if (cpu_reset !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL good_status idle=%0d: cpu_reset=%b err=%b want 0 0", idle, cpu_reset, err); end
   endtask

   task automatic test_bad_checksum();
      int base;
      base = wr_total;
      send_frame(0, 8'hD6);
      n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL badsum_err: got %b want 1", err); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL badsum_done: got %b want 0", done); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_errors++; $display("FAIL badsum_cpu_reset: got %b want 1", cpu_reset); end
      n_checks++; if (wr_total - base !== 2) begin n_errors++; $display("FAIL badsum_wr_count: got %0d want 2", wr_total - base); end
      n_checks++; if (log_data[base+1] !== 32'hAC020054) begin n_errors++; $display("FAIL badsum_word1: got %h want ac020054", log_data[base+1]); end
   endtask

   task automatic test_bad_count();
      logic [7:0] counts [2] = '{8'h00, 8'h41};
      int base;
      for (int k = 0; k < 2; k++) begin
         base = wr_total;
         send_byte(8'hA5, 0);
         send_byte(counts[k], 0);
         n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL badcnt_err cnt=%h: got %b want 1", counts[k], err); end
         n_checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL badcnt_status cnt=%h: cpu_reset=%b done=%b want 1 0", counts[k], cpu_reset, done); end
         // Bytes following a rejected count must be ignored.
         send_byte(8'h11, 0);
         send_byte(8'h22, 0);
         send_byte(8'h33, 0);
         send_byte(8'h44, 2);
         n_checks++; if (wr_total - base !== 0) begin n_errors++; $display("FAIL badcnt_no_write cnt=%h: got %0d want 0", counts[k], wr_total - base); end
      end
   endtask

   task automatic test_full_count();
      int base;
      logic [31:0] w;
      logic [7:0]  csum;
      base = wr_total;
      csum = 8'h00;
      send_byte(8'hA5, 0);
      send_byte(8'h40, 0);
      n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL full_accept: err=%b done=%b want 0 0", err, done); end
      for (int i = 0; i < 64; i++) begin
         w = full_word(i);
         csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_byte(w[31:24], 0);
         send_byte(w[23:16], 0);
         send_byte(w[15:8], 0);
         send_byte(w[7:0], 0);
      end
      send_byte(csum, 0);
      n_checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_errors++; $display("FAIL full_done: done=%b cpu_reset=%b want 1 0", done, cpu_reset); end
      n_checks++; if (wr_total - base !== 64) begin n_errors++; $display("FAIL full_wr_count: got %0d want 64", wr_total - base); end
      n_checks++; if (log_addr[base] !== 6'd0 || log_data[base] !== full_word(0)) begin n_errors++; $display("FAIL full_first: got %h/%h want 00/%h", log_addr[base], log_data[base], full_word(0)); end
      n_checks++; if (log_addr[base+63] !== 6'd63 || log_data[base+63] !== full_word(63)) begin n_errors++; $display("FAIL full_last: got %h/%h want 3f/%h", log_addr[base+63], log_data[base+63], full_word(63)); end
   endtask

   task automatic test_junk();
      int base;
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      base = wr_total;
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 0);
      n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL junk_hold: err=%b done=%b want 1 0", err, done); end
      send_frame(0, 8'hD7);
      n_checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b0) begin n_errors++; $display("FAIL junk_status: done=%b err=%b cpu_reset=%b want 1 0 0", done, err, cpu_reset); end
      n_checks++; if (wr_total - base !== 2 || log_data[base] !== 32'h20080005 || log_data[base+1] !== 32'hAC020054) begin n_errors++; $display("FAIL junk_words: n=%0d got %h %h", wr_total - base, log_data[base], log_data[base+1]); end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      base = wr_total;
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (cpu_reset !== 1'b1 || bus.im_we !== 1'b0) begin n_errors++; $display("FAIL midrst_during: cpu_reset=%b im_we=%b want 1 0", cpu_reset, bus.im_we); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (wr_total - base !== 0) begin n_errors++; $display("FAIL midrst_no_write: got %0d want 0", wr_total - base); end
      n_checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL midrst_status: cpu_reset=%b done=%b err=%b want 1 0 0", cpu_reset, done, err); end
      send_frame(0, 8'hD7);
      n_checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_errors++; $display("FAIL midrst_reload: done=%b cpu_reset=%b want 1 0", done, cpu_reset); end
      n_checks++; if (wr_total - base !== 2 || log_addr[base] !== 6'd0 || log_data[base] !== 32'h20080005) begin n_errors++; $display("FAIL midrst_words: n=%0d got %h/%h", wr_total - base, log_addr[base], log_data[base]); end
   endtask

   task automatic test_resync_after_done();
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL resync_pre: done=%b want 1", done); end
      send_byte(8'hA5, 0);
      n_checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL resync_clear: cpu_reset=%b done=%b want 1 0", cpu_reset, done); end
      for (int i = 1; i < 11; i++) send_byte(good_fr[i], 0);
      n_checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_errors++; $display("FAIL resync_done: done=%b cpu_reset=%b want 1 0", done, cpu_reset); end
   endtask

   initial begin
      test_reset();
      test_good_frame(0);
      test_good_frame(3);
      test_bad_checksum();
      test_bad_count();
      test_full_count();
      test_junk();
      test_reset_mid_frame();
      test_resync_after_done();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
